ibuf_fill: RTL and testbench

The input-buffer fill stage sits directly downstream of `addr_gen` on the AXI read-data channel. It accepts the burst beats returned for each `araddr`/`arburst` request and writes them into an on-chip tile buffer of `ROWS = (POY-1)*STRIDE + KSIZE` rows × `BURST` words. When a whole tile is present, it signals the PE-side reader, serves random-access reads from the tile, and frees the tile when the reader releases it.

---
 rtl/ibuf_fill.sv | 139 +++++++++++++
 tb/tb_ibuf_fill.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_fill.sv
// ibuf_fill: AXI read-data beats into a ROWS x BURST tile buffer, served to the PE reader.
// Define IBUF_PINGPONG_EN for two tile banks (fill one while the other is read).
module ibuf_fill #(
    parameter int DW     = 32,
    parameter int KSIZE  = 3,
    parameter int POY    = 3,
    parameter int STRIDE = 1,
    parameter int BURST  = 16,
    localparam int ROWS  = (POY - 1) * STRIDE + KSIZE,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(BURST)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] rdata,
    input  logic          rvalid,
    input  logic          rlast,
    output logic          rready,
    output logic          tile_valid,
    output logic          fill_done,
    input  logic          tile_release,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [DW-1:0] rd_data,
    output logic          burst_err
);

`ifdef IBUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = $clog2(NB * ROWS * BURST);

    logic [DW-1:0] mem [NB*ROWS*BURST];
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          wr_bank;
    logic          rd_bank;
    logic          full_wr;
    logic          full_rd;
    logic          acc;
    logic          last_col;
    logic          last_row;
    logic          tile_done;
    logic          rel;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;

    assign rready     = !full_wr;
    assign tile_valid = full_rd;
    assign acc        = rvalid && rready;
    assign last_col   = col == CW'(BURST - 1);
    assign last_row   = row == RW'(ROWS - 1);
    assign tile_done  = acc && last_col && last_row;
    assign rel        = tile_release && tile_valid;

    assign wa = AW'((32'(wr_bank) * ROWS + 32'(row)) * BURST + 32'(col));
    assign ra = AW'((32'(rd_bank) * ROWS + 32'(rd_row)) * BURST + 32'(rd_col));

`ifdef IBUF_PINGPONG_EN
    logic [1:0] full;
    logic [1:0] full_nxt;

    assign full_wr = full[wr_bank];
    assign full_rd = full[rd_bank];

    // Completion and release always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (tile_done) full_nxt[wr_bank] = 1'b1;
        if (rel)       full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (tile_done) wr_bank <= !wr_bank;
            if (rel)       rd_bank <= !rd_bank;
        end
    end
`else
    logic full;

    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
    assign full_wr = full;
    assign full_rd = full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (tile_done) begin
            full <= 1'b1;
        end else if (rel) begin
            full <= 1'b0;
        end
    end
`endif

    // Position advances by beat count only; rlast is checked, never obeyed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            fill_done <= 1'b0;
            burst_err <= 1'b0;
        end else begin
            fill_done <= tile_done;
            if (acc) begin
                if (rlast != last_col) burst_err <= 1'b1;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem[wa] <= rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[ra];
        end
    end

endmodule

// File: tb/tb_ibuf_fill.sv
// tb_ibuf_fill: random and directed beats checked against a tile-queue model.
// Model: completed tiles sit in a FIFO of capacity 1 (or 2 with IBUF_PINGPONG_EN).
module tb_ibuf_fill;

    localparam int DW    = 32;
    localparam int BURST = 16;
    localparam int ROWS  = 5;
    localparam int TW    = ROWS * BURST;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(BURST);
`ifdef IBUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;
    logic          rready;
    logic          tile_valid;
    logic          fill_done;
    logic          tile_release;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [DW-1:0] rd_data;
    logic          burst_err;

    ibuf_fill #(
        .DW(DW), .KSIZE(3), .POY(3), .STRIDE(1), .BURST(BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdata(rdata), .rvalid(rvalid),
        .rlast(rlast), .rready(rready), .tile_valid(tile_valid),
        .fill_done(fill_done), .tile_release(tile_release),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .burst_err(burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] done_q[$];
    logic [DW-1:0] part_q[$];
    bit            m_err;
    bit            m_fd;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;
    int            fd_cnt;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check rready before the edge, rest after.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit l,
                        input bit rel, input bit re, input int r, input int c);
        bit acc;
        bit tv;
        rvalid = v; rdata = d; rlast = l;
        tile_release = rel; rd_en = re;
        rd_row = RW'(r); rd_col = CW'(c);
        #1;
        tv  = done_q.size() > 0;
        acc = v && (done_q.size() < NB);
        check("rready", rready, done_q.size() < NB);
        @(posedge clk);
        if (re) begin
            if (tv) begin
                m_rd = done_q[r * BURST + c];
                m_rd_known = 1;
            end else begin
                m_rd_known = 0;
            end
        end
        if (rel && tv) repeat (TW) done_q.delete(0);
        m_fd = 0;
        if (acc) begin
            if (l != ((part_q.size() % BURST) == BURST - 1)) m_err = 1;
            part_q.push_back(d);
            if (part_q.size() == TW) begin
                foreach (part_q[i]) done_q.push_back(part_q[i]);
                part_q.delete();
                m_fd = 1;
            end
        end
        #1;
        if (fill_done) fd_cnt++;
        check("fill_done", fill_done, m_fd);
        check("tile_valid", tile_valid, done_q.size() > 0);
        check("burst_err", burst_err, m_err);
        if (m_rd_known) check("rd_data", rd_data, m_rd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        rvalid = 0; rdata = '0; rlast = 0;
        tile_release = 0; rd_en = 0; rd_row = '0; rd_col = '0;
        #1;
        check("rst_rready", rready, 1);
        check("rst_tile_valid", tile_valid, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_burst_err", burst_err, 0);
        done_q.delete();
        part_q.delete();
        m_err = 0; m_fd = 0; m_rd = '0; m_rd_known = 1; fd_cnt = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Offer n beats (base+k) with rvalid held, bounded by a cycle budget.
    task automatic fill(input int n, input int base, input bit bad9);
        int sent;
        int guard;
        int col;
        bit ok;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 4 * n + 10) begin
            col = part_q.size() % BURST;
            ok  = done_q.size() < NB;
            step(1, DW'(base + sent), (col == BURST - 1) || (bad9 && sent == 9), 0, 0, 0, 0);
            if (ok) sent++;
            guard++;
        end
        if (sent < n) check("fill_timeout", sent, n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < TW; i++) step(1, DW'(i), (i % BURST) == BURST - 1, 0, 0, 0, 0);
        step(0, '0, 0, 0, 1, 3, 7);
        check("rd_3_7", rd_data, 55);
        step(0, '0, 0, 1, 0, 0, 0);
        fill(TW, 1000, 0);
        step(0, '0, 0, 0, 1, 0, 0);
        check("rd_0_0_new", rd_data, 1000);
        step(0, '0, 0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 0, 0, 0);

`ifdef IBUF_PINGPONG_EN
        do_reset();
        fill(TW, 0, 0);
        fill(TW, 100, 0);
        step(0, '0, 0, 0, 0, 0, 0);
        check("pp_full_rready", rready, 0);
        step(0, '0, 0, 1, 0, 0, 0);
        fill(TW, 200, 0);
        step(0, '0, 0, 0, 1, 2, 5);
        check("pp_rd_bank1", rd_data, 100 + 2 * BURST + 5);

        do_reset();
        fill(TW, 0, 0);
        fill(TW - 1, 500, 0);
        step(1, DW'(500 + TW - 1), 1, 1, 0, 0, 0);
        check("pp_sim_valid", tile_valid, 1);
        step(0, '0, 0, 0, 1, 0, 1);
        check("pp_sim_rd", rd_data, 501);
`endif

        do_reset();
        fill(TW, 0, 1);
        check("err_sticky", burst_err, 1);
        check("err_fd_cnt", fd_cnt, 1);
        step(0, '0, 0, 0, 0, 0, 0);
        check("err_hold", burst_err, 1);

        do_reset();
        fill(37, 0, 0);
        do_reset();
        fill(TW, 300, 0);
        step(0, '0, 0, 0, 0, 0, 0);
        check("rst_mid_fd_once", fd_cnt, 1);

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int col;
            col = part_q.size() % BURST;
            step(($urandom % 4) != 0, $urandom, col == BURST - 1,
                 ($urandom % 24) == 0, ($urandom % 3) == 0,
                 $urandom_range(ROWS - 1), $urandom_range(BURST - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
